mac_round_seq: RTL and testbench

- Sequencer for the fixed-point dot-product datapath.
- Accepts a stream of signed Q(INT_BITS).(FRAC_BITS) operand pairs and multiplies each pair at full precision.
- Accumulates VEC_LEN products, then applies round-half-up and saturation back to INT_BITS+FRAC_BITS bits.
- Emits one result per vector over a valid/ready handshake; sits between the operand fetch stage and the result writeback buffer.

---
 rtl/mac_round_seq.sv | 130 +++++++++++++
 tb/tb_mac_round_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_round_seq.sv
// mac_round_seq: fixed-point dot-product sequencer (multiply, accumulate, round-half-up, saturate).
// Optional MAC_ROUND_SAT_FLAG_EN adds sat_o, flagging a clamped result.
module mac_round_seq #(
    parameter int INT_BITS  = 7,
    parameter int FRAC_BITS = 9,
    parameter int VEC_LEN   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [INT_BITS+FRAC_BITS-1:0] a_i,
    input  logic [INT_BITS+FRAC_BITS-1:0] b_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [INT_BITS+FRAC_BITS-1:0] out_o
`ifdef MAC_ROUND_SAT_FLAG_EN
    ,
    output logic                          sat_o
`endif
);

    localparam int W     = INT_BITS + FRAC_BITS;
    localparam int ACC_W = 2 * W + $clog2(VEC_LEN) + 1;
    localparam int R_W   = ACC_W - FRAC_BITS + 1;
    localparam int CNT_W = $clog2(VEC_LEN + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        ROUND,
        OUT
    } state_t;

    state_t                   state;
    logic signed [ACC_W-1:0]  acc;
    logic        [CNT_W-1:0]  cnt;

    logic signed [2*W-1:0]    a_ext;
    logic signed [2*W-1:0]    b_ext;
    logic signed [2*W-1:0]    prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [R_W-1:0]    r;
    logic                     ovf;
    logic                     sat_pos;
    logic                     sat_neg;
    logic        [W-1:0]      rounded;

    assign in_ready_o = (state == IDLE) || (state == ACCUM);

    // Operands widened first so the product is exact at 2W bits.
    assign a_ext    = {{W{a_i[W-1]}}, a_i};
    assign b_ext    = {{W{b_i[W-1]}}, b_i};
    assign prod     = a_ext * b_ext;
    assign prod_ext = {{(ACC_W-2*W){prod[2*W-1]}}, prod};

    // One extra sign bit keeps the half-LSB increment from wrapping.
    assign r = {acc[ACC_W-1], acc[ACC_W-1:FRAC_BITS]}
             + {{(R_W-1){1'b0}}, acc[FRAC_BITS-1]};

    // r fits in W bits only when its bits from W-1 upward are all equal.
    assign ovf     = !((&r[R_W-1:W-1]) || !(|r[R_W-1:W-1]));
    assign sat_pos = ovf && !r[R_W-1];
    assign sat_neg = ovf && r[R_W-1];

    always_comb begin
        rounded = r[W-1:0];
        if (sat_pos)
            rounded = {1'b0, {(W-1){1'b1}}};
        else if (sat_neg)
            rounded = {1'b1, {(W-1){1'b0}}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            out_valid_o <= 1'b0;
            out_o       <= '0;
`ifdef MAC_ROUND_SAT_FLAG_EN
            sat_o       <= 1'b0;
`endif
        end else if (clear_i) begin
            // Abort wins over any beat or pending result; out_o keeps its last value.
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            out_valid_o <= 1'b0;
`ifdef MAC_ROUND_SAT_FLAG_EN
            sat_o       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        acc   <= prod_ext;
                        cnt   <= CNT_W'(1);
                        state <= (VEC_LEN == 1) ? ROUND : ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid_i) begin
                        acc <= acc + prod_ext;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(VEC_LEN - 1))
                            state <= ROUND;
                    end
                end
                ROUND: begin
                    out_o       <= rounded;
                    out_valid_o <= 1'b1;
`ifdef MAC_ROUND_SAT_FLAG_EN
                    sat_o       <= sat_pos || sat_neg;
`endif
                    state       <= OUT;
                end
                OUT: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_round_seq.sv
// Randomized and directed bench for mac_round_seq against an integer dot-product model.
// Define MAC_ROUND_SAT_FLAG_EN to also check sat_o.
`timescale 1ns/1ps
module tb_mac_round_seq;

    localparam int W = 16;
    localparam int F = 9;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clear = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] out;
`ifdef MAC_ROUND_SAT_FLAG_EN
    logic         sat;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_vec    = 0;

    logic [W-1:0] va [N];
    logic [W-1:0] vb [N];

    always #5 clk = ~clk;

    mac_round_seq #(.INT_BITS(7), .FRAC_BITS(F), .VEC_LEN(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (clear),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_o       (out)
`ifdef MAC_ROUND_SAT_FLAG_EN
        ,
        .sat_o       (sat)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Exact dot product, then floor((sum + half LSB) / LSB) and clamp to W signed bits.
    function automatic void model(output logic [W-1:0] res, output logic sat_exp);
        longint sum = 0;
        longint r;
        longint hi = (longint'(1) <<< (W-1)) - 1;
        longint lo = -(longint'(1) <<< (W-1));
        for (int i = 0; i < N; i++)
            sum += longint'($signed(va[i])) * longint'($signed(vb[i]));
        r = (sum + (longint'(1) <<< (F-1))) >>> F;
        sat_exp = 1'b0;
        if (r > hi) begin
            r = hi;
            sat_exp = 1'b1;
        end else if (r < lo) begin
            r = lo;
            sat_exp = 1'b1;
        end
        res = r[W-1:0];
    endfunction

    task automatic set_all(input logic [W-1:0] av, input logic [W-1:0] bv);
        for (int i = 0; i < N; i++) begin
            va[i] = av;
            vb[i] = bv;
        end
    endtask

    // Presents the N beats of va/vb with optional idle gaps; returns at the cycle after the last beat.
    task automatic feed(input string tag, input int gap_max);
        for (int i = 0; i < N; i++) begin
            repeat ($urandom_range(gap_max, 0)) begin
                @(negedge clk);
                in_valid  = 1'b0;
                out_ready = 1'($urandom_range(1, 0));
            end
            @(negedge clk);
            in_valid  = 1'b1;
            a         = va[i];
            b         = vb[i];
            out_ready = 1'($urandom_range(1, 0));
            check({tag, " in_ready_beat"}, in_ready, 1);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        a         = W'($urandom);
        b         = W'($urandom);
        out_ready = 1'b0;
    endtask

    // Called right after feed: checks latency, result, backpressure hold and handshake.
    task automatic result(input string tag, input int bp);
        logic [W-1:0] er;
        logic         es;
        logic [W-1:0] held;
        model(er, es);
        check({tag, " valid_n1"}, out_valid, 0);
        check({tag, " ready_round"}, in_ready, 0);
        @(negedge clk);
        check({tag, " valid_n2"}, out_valid, 1);
        check({tag, " out"}, out, er);
`ifdef MAC_ROUND_SAT_FLAG_EN
        check({tag, " sat"}, sat, es);
`endif
        held = out;
        for (int k = 0; k < bp; k++) begin
            in_valid = 1'($urandom_range(1, 0));
            @(negedge clk);
            check({tag, " bp_valid"}, out_valid, 1);
            check({tag, " bp_out"}, out, held);
            check({tag, " bp_ready"}, in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " hs_valid"}, out_valid, 0);
        check({tag, " hs_ready"}, in_ready, 1);
        n_vec++;
        $display("vector %0d %s: out=0x%h expected=0x%h sat_expected=%0d bp=%0d",
                 n_vec, tag, out, er, es, bp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] held;

        repeat (2) @(negedge clk);
        check("reset valid", out_valid, 0);
        check("reset ready", in_ready, 1);
        check("reset out", out, 0);
        rst = 1'b0;

        set_all(16'h0200, 16'h0200);
        feed("unit", 0); result("unit", 0);

        set_all(16'h0000, 16'h0000); va[0] = 16'h0001; vb[0] = 16'h0100;
        feed("round_half_pos", 0); result("round_half_pos", 0);
        va[0] = 16'h0001; vb[0] = 16'h00FF;
        feed("round_below_half", 0); result("round_below_half", 0);
        va[0] = 16'hFFFF; vb[0] = 16'h0100;
        feed("round_half_neg", 0); result("round_half_neg", 0);

        set_all(16'h7FFF, 16'h7FFF);
        feed("sat_pos", 0); result("sat_pos", 0);
        set_all(16'h8000, 16'h7FFF);
        feed("sat_neg", 0); result("sat_neg", 0);

        set_all(16'h0200, 16'h0200);
        feed("backpressure", 1); result("backpressure", 5);

        // Abort: two beats, then clear together with a third beat.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = 16'h7FFF;
            b = 16'h7FFF;
            clear = (i == 2);
        end
        @(negedge clk);
        clear = 1'b0;
        in_valid = 1'b0;
        check("abort valid", out_valid, 0);
        check("abort ready", in_ready, 1);
        set_all(16'h0200, 16'h0200);
        feed("after_abort", 0); result("after_abort", 0);

        // Clear while a result is waiting drops it and leaves out_o alone.
        set_all(16'h0300, 16'h0100);
        feed("clear_out", 0);
        @(negedge clk);
        check("clear_out pre_valid", out_valid, 1);
        held = out;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_out valid", out_valid, 0);
        check("clear_out out", out, held);
        check("clear_out ready", in_ready, 1);

        // Async reset inside ACCUM.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = 16'h7FFF;
            b = 16'h7FFF;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_accum valid", out_valid, 0);
        check("rst_accum ready", in_ready, 1);
        #1 rst = 1'b0;
        set_all(16'h0200, 16'h0200);
        feed("after_rst_accum", 0); result("after_rst_accum", 0);

        // Async reset while a result is held.
        set_all(16'h0400, 16'h0400);
        feed("rst_out", 0);
        @(negedge clk);
        check("rst_out pre_valid", out_valid, 1);
        #1 rst = 1'b1;
        #1;
        check("rst_out valid", out_valid, 0);
        check("rst_out ready", in_ready, 1);
        check("rst_out out", out, 0);
        #1 rst = 1'b0;
        set_all(16'hFE00, 16'h0180);
        feed("after_rst_out", 0); result("after_rst_out", 0);

        // Random vectors: mostly in-range magnitudes, some full-range to hit saturation.
        for (int v = 0; v < 24; v++) begin
            bit full;
            full = ($urandom_range(3, 0) == 0);
            for (int i = 0; i < N; i++) begin
                if (full) begin
                    va[i] = W'($urandom);
                    vb[i] = W'($urandom);
                end else begin
                    va[i] = W'($urandom_range(4095, 0)) - 16'd2048;
                    vb[i] = W'($urandom_range(4095, 0)) - 16'd2048;
                end
            end
            feed("random", 2);
            result("random", $urandom_range(3, 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
